// File: rtl/vector_pkg.sv
//------------------------------------------------------------------------------
// vector_pkg
//   Shared types and constants for the vector DAC SPI engine: the DAC code
//   width, the 16-bit command frame layout bits and the engine state enum.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vector_pkg;

   // Native resolution of the dual-channel DAC
   localparam int DAC_WIDTH   = 12;
   localparam int FRAME_WIDTH = 16;

   // Command frame configuration bits
   localparam logic C_CH_X     = 1'b0;   // channel A carries X
   localparam logic C_CH_Y     = 1'b1;   // channel B carries Y
   localparam logic C_BUF      = 1'b0;   // unbuffered reference
   localparam logic C_GA_N     = 1'b1;   // 1x gain
   localparam logic C_SHDN_N   = 1'b1;   // output active

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_X  = 3'd1,
      ST_SHIFT_X = 3'd2,
      ST_GAP     = 3'd3,
      ST_LOAD_Y  = 3'd4,
      ST_SHIFT_Y = 3'd5,
      ST_LATCH   = 3'd6
   } state_t;

   // Assemble one DAC command word: channel, config bits, 12-bit code
   function automatic logic [FRAME_WIDTH-1:0] dac_frame(
      input logic                 ch,
      input logic [DAC_WIDTH-1:0] code
   );
      return {ch, C_BUF, C_GA_N, C_SHDN_N, code};
   endfunction

endpackage

`default_nettype wire

// File: rtl/point_fifo.sv
//------------------------------------------------------------------------------
// point_fifo
//   Synchronous FIFO with registered full/empty flags. Read data is
//   show-ahead (head entry visible on o_data while not empty). A push on a
//   full FIFO is accepted when a pop happens in the same cycle.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     i_push, i_data    write request and data
//     i_pop             read request (ignored when empty)
//     o_data            head entry
//     o_full, o_empty   occupancy flags
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module point_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic             r_full;
   logic             r_empty;

   logic             w_pop_ok;
   logic             w_push_ok;
   logic [AW-1:0]    w_wr_ptr_inc;
   logic [AW-1:0]    w_rd_ptr_inc;

   assign w_pop_ok     = i_pop && !r_empty;
   // A simultaneous pop frees the slot the push needs
   assign w_push_ok    = i_push && (!r_full || w_pop_ok);
   // Depth is a power of two, so pointers wrap naturally
   assign w_wr_ptr_inc = r_wr_ptr + AW'(1);
   assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= w_wr_ptr_inc;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end
         if (w_push_ok && !w_pop_ok) begin
            r_empty <= 1'b0;
            r_full  <= (w_wr_ptr_inc == r_rd_ptr);
         end else if (w_pop_ok && !w_push_ok) begin
            r_full  <= 1'b0;
            r_empty <= (w_rd_ptr_inc == r_wr_ptr);
         end
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

`default_nettype wire

// File: rtl/vector_dac_spi.sv
//------------------------------------------------------------------------------
// vector_dac_spi
//   Buffers (x, y) points from a line rasteriser and streams each one to a
//   dual-channel 12-bit SPI DAC as two 16-bit frames (X on channel A, Y on
//   channel B), then pulses ldac_n so both outputs update together.
//   Ports:
//     clk, rst          clock, asynchronous active-low reset
//     wr, x_in, y_in    point strobe and coordinates
//     ready             FIFO not full
//     overflow          sticky: a point was dropped on a full FIFO
//     sclk, mosi, cs_n  SPI mode 0, MSB first
//     ldac_n            DAC latch strobe, active low
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vector_dac_spi
   import vector_pkg::*;
#(
   parameter int OUT_WIDTH   = 8,
   parameter int SCLK_DIV    = 4,
   parameter int CS_GAP      = 2,
   parameter int LDAC_CYCLES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr,
   input  logic [OUT_WIDTH-1:0] x_in,
   input  logic [OUT_WIDTH-1:0] y_in,
   output logic                 ready,
   output logic                 overflow,
   output logic                 sclk,
   output logic                 mosi,
   output logic                 cs_n,
   output logic                 ldac_n
);

   localparam int          PW          = 2 * OUT_WIDTH;
   localparam logic [15:0] C_DIV_LAST  = 16'(SCLK_DIV - 1);
   localparam logic [15:0] C_GAP_LAST  = 16'(CS_GAP - 1);
   localparam logic [15:0] C_LDAC_LAST = 16'(LDAC_CYCLES - 1);
   localparam logic [4:0]  C_HALF_LAST = 5'd31;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [15:0]            r_cnt;        // clk cycles within a half-period / gap / latch
   logic [15:0]            w_cnt_next;
   logic [4:0]             r_half;       // SCLK half-period index, odd = sclk high
   logic [4:0]             w_half_next;
   logic [FRAME_WIDTH-1:0] r_shift;
   logic [OUT_WIDTH-1:0]   r_y;          // Y held while the X frame is on the wire
   logic                   r_overflow;

   logic [PW-1:0]          w_fifo_data;
   logic [OUT_WIDTH-1:0]   w_fifo_x;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_pop;
   logic                   w_load_x;
   logic                   w_load_y;
   logic                   w_shift_en;
   logic [DAC_WIDTH-1:0]   w_x_code;
   logic [DAC_WIDTH-1:0]   w_y_code;
   logic                   w_cs_n;
   logic                   w_sclk;
   logic                   w_mosi;
   logic                   w_ldac_n;

   point_fifo #(
      .WIDTH (PW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (wr),
      .i_pop   (w_pop),
      .i_data  ({x_in, y_in}),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_fifo_x = w_fifo_data[PW-1:OUT_WIDTH];

   // Coordinates are left-justified into the DAC code word
   if (OUT_WIDTH >= DAC_WIDTH) begin : g_trunc
      assign w_x_code = w_fifo_x[OUT_WIDTH-1 -: DAC_WIDTH];
      assign w_y_code = r_y[OUT_WIDTH-1 -: DAC_WIDTH];
   end else begin : g_pad
      assign w_x_code = {w_fifo_x, {(DAC_WIDTH-OUT_WIDTH){1'b0}}};
      assign w_y_code = {r_y, {(DAC_WIDTH-OUT_WIDTH){1'b0}}};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // The SHIFT phase starts with sclk low, so the 16th falling edge is the
   // transition out of SHIFT, which is also where cs_n rises.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt + 16'd1;
      w_half_next  = r_half;
      w_pop        = 1'b0;
      w_load_x     = 1'b0;
      w_load_y     = 1'b0;
      w_shift_en   = 1'b0;
      w_cs_n       = 1'b1;
      w_sclk       = 1'b0;
      w_mosi       = 1'b0;
      w_ldac_n     = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_cnt_next  = '0;
            w_half_next = '0;
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_load_x     = 1'b1;
               w_state_next = ST_LOAD_X;
            end
         end
         ST_LOAD_X, ST_LOAD_Y: begin
            w_cs_n       = 1'b0;
            w_mosi       = r_shift[FRAME_WIDTH-1];
            w_cnt_next   = '0;
            w_half_next  = '0;
            w_state_next = (r_state == ST_LOAD_X) ? ST_SHIFT_X : ST_SHIFT_Y;
         end
         ST_SHIFT_X, ST_SHIFT_Y: begin
            w_cs_n = 1'b0;
            w_sclk = r_half[0];
            w_mosi = r_shift[FRAME_WIDTH-1];
            if (r_cnt == C_DIV_LAST) begin
               w_cnt_next  = '0;
               w_half_next = r_half + 5'd1;
               if (r_half == C_HALF_LAST) begin
                  w_state_next = (r_state == ST_SHIFT_X) ? ST_GAP : ST_LATCH;
               end else if (r_half[0]) begin
                  // end of a high half-period: falling edge, advance a bit
                  w_shift_en = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (r_cnt == C_GAP_LAST) begin
               w_cnt_next   = '0;
               w_load_y     = 1'b1;
               w_state_next = ST_LOAD_Y;
            end
         end
         ST_LATCH: begin
            w_ldac_n = 1'b0;
            if (r_cnt == C_LDAC_LAST) begin
               w_cnt_next   = '0;
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt      <= '0;
         r_half     <= '0;
         r_shift    <= '0;
         r_y        <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_next;
         r_half <= w_half_next;
         if (w_load_x) begin
            r_shift <= dac_frame(C_CH_X, w_x_code);
            r_y     <= w_fifo_data[OUT_WIDTH-1:0];
         end else if (w_load_y) begin
            r_shift <= dac_frame(C_CH_Y, w_y_code);
         end else if (w_shift_en) begin
            r_shift <= {r_shift[FRAME_WIDTH-2:0], 1'b0};
         end
         // A write on a full FIFO is only lost when no pop frees a slot
         if (wr && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign ready    = !w_full;
   assign overflow = r_overflow;
   assign sclk     = w_sclk;
   assign mosi     = w_mosi;
   assign cs_n     = w_cs_n;
   assign ldac_n   = w_ldac_n;

endmodule

`default_nettype wire

// File: tb/tb_vector_dac_spi.sv
//------------------------------------------------------------------------------
// tb_vector_dac_spi
//   Self-checking bench for vector_dac_spi. Expected frames are queued when
//   points are written and compared by an SPI monitor as frames complete.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vector_dac_spi;

   localparam int DIV    = 4;
   localparam int GAP    = 2;
   localparam int LDAC   = 2;
   localparam int PERIOD = 2 + 64*DIV + GAP + LDAC;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr  = 1'b0;
   logic [7:0] x_in = 8'h00;
   logic [7:0] y_in = 8'h00;
   logic       ready, overflow, sclk, mosi, cs_n, ldac_n;

   vector_dac_spi #(
      .OUT_WIDTH   (8),
      .SCLK_DIV    (DIV),
      .CS_GAP      (GAP),
      .LDAC_CYCLES (LDAC),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr),
      .x_in     (x_in),
      .y_in     (y_in),
      .ready    (ready),
      .overflow (overflow),
      .sclk     (sclk),
      .mosi     (mosi),
      .cs_n     (cs_n),
      .ldac_n   (ldac_n)
   );

   always #5 clk = ~clk;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [15:0] sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   //--------------------------------------------------------------------------
   // SPI / LDAC monitor, sampled on the falling clk edge
   //--------------------------------------------------------------------------
   int          cyc = 0;
   int          m_nbits = 0, m_rises = 0, m_ldac_pulses = 0;
   int          m_last_edge = 0, m_xfall = 0, m_xrise = 0;
   int          m_ldac_fall = 0, m_ldac_rise = 0, m_since_ldac = 0;
   logic        m_prev_sclk = 1'b0, m_prev_cs = 1'b1, m_prev_ldac = 1'b1, m_prev_mosi = 1'b0;
   logic        m_inframe = 1'b0, m_fidx = 1'b1, m_ydone = 1'b0;
   logic        m_sclk_valid = 1'b0, m_ldac_bad = 1'b0;
   logic [15:0] m_shreg = '0;
   logic [15:0] m_exp;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         m_prev_sclk  = 1'b0;
         m_prev_cs    = 1'b1;
         m_prev_ldac  = 1'b1;
         m_prev_mosi  = 1'b0;
         m_nbits      = 0;
         m_inframe    = 1'b0;
         m_fidx       = 1'b1;
         m_ydone      = 1'b0;
         m_sclk_valid = 1'b0;
      end else begin
         // frame start
         if (!cs_n && m_prev_cs) begin
            m_fidx       = ~m_fidx;
            m_inframe    = 1'b1;
            m_nbits      = 0;
            m_shreg      = '0;
            m_last_edge  = cyc;
            m_sclk_valid = 1'b0;
            if (m_fidx == 1'b0) begin
               m_xfall      = cyc;
               m_since_ldac = cyc - m_ldac_rise;
            end else begin
               chk("cs_gap", cyc - m_xrise, GAP);
            end
         end
         if (m_inframe && !cs_n) begin
            if (sclk && !m_prev_sclk) begin
               if (m_sclk_valid) chk("sclk_low", cyc - m_last_edge, DIV);
               m_shreg     = {m_shreg[14:0], mosi};
               m_nbits++;
               m_rises++;
               m_last_edge = cyc;
            end
            if (!sclk && m_prev_sclk) begin
               chk("sclk_high", cyc - m_last_edge, DIV);
               m_last_edge  = cyc;
               m_sclk_valid = 1'b1;
            end
            if (!m_prev_cs && (mosi !== m_prev_mosi))
               chk("mosi_on_fall", m_prev_sclk && !sclk, 1);
         end
         // frame end
         if (cs_n && !m_prev_cs && m_inframe) begin
            chk("cs_rise_on_fall", m_prev_sclk && !sclk, 1);
            chk("sclk_high_last", cyc - m_last_edge, DIV);
            chk("frame_bits", m_nbits, 16);
            if (sb_q.size() == 0) begin
               chk("frame_unexpected", m_shreg, 32'hFFFF_FFFF);
            end else begin
               m_exp = sb_q.pop_front();
               chk("frame", m_shreg, m_exp);
            end
            if (m_fidx == 1'b0) m_xrise = cyc;
            else                m_ydone = 1'b1;
            m_inframe = 1'b0;
         end
         // latch pulse
         if (!ldac_n && m_prev_ldac) begin
            chk("ldac_after_y", m_ydone, 1);
            m_ydone     = 1'b0;
            m_ldac_fall = cyc;
            m_ldac_bad  = 1'b0;
         end
         if (!ldac_n && (cs_n !== 1'b1 || sclk !== 1'b0)) m_ldac_bad = 1'b1;
         if (ldac_n && !m_prev_ldac) begin
            chk("ldac_width", cyc - m_ldac_fall, LDAC);
            chk("ldac_quiet", m_ldac_bad, 0);
            chk("point_period", cyc - m_xfall, PERIOD);
            m_ldac_rise = cyc;
            m_ldac_pulses++;
         end
         m_prev_sclk = sclk;
         m_prev_cs   = cs_n;
         m_prev_ldac = ldac_n;
         m_prev_mosi = mosi;
      end
   end

   //--------------------------------------------------------------------------
   // Stimulus helpers
   //--------------------------------------------------------------------------
   task automatic drive_point(input logic [7:0] x, input logic [7:0] y,
                              input logic [15:0] ea, input logic [15:0] eb);
      @(posedge clk); #1;
      wr = 1'b1; x_in = x; y_in = y;
      sb_q.push_back(ea);
      sb_q.push_back(eb);
      @(posedge clk); #1;
      wr = 1'b0;
   endtask

   function automatic logic [15:0] frame_x(input logic [7:0] v);
      return {4'h3, v, 4'h0};
   endfunction

   function automatic logic [15:0] frame_y(input logic [7:0] v);
      return {4'hB, v, 4'h0};
   endfunction

   task automatic wait_drain(input string name);
      int t = 0;
      while (sb_q.size() != 0 && t < 4000) begin
         @(posedge clk);
         t++;
      end
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_drain: %0d frames still pending, required 0", name, sb_q.size());
         sb_q.delete();
      end
      repeat (LDAC + 4) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   typedef struct {
      logic [7:0]  x;
      logic [7:0]  y;
      logic [15:0] ea;
      logic [15:0] eb;
   } vec_t;

   vec_t tbl[4];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int   r0, p0;
      logic prev, found;

      tbl[0] = '{8'hA5, 8'h3C, 16'h3A50, 16'hB3C0};
      tbl[1] = '{8'h00, 8'hFF, 16'h3000, 16'hBFF0};
      tbl[2] = '{8'hFF, 8'h00, 16'h3FF0, 16'hB000};
      tbl[3] = '{8'h12, 8'h80, 16'h3120, 16'hB800};

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_ldac_n", ldac_n, 1);
      chk("rst_overflow", overflow, 0);
      chk("rst_ready", ready, 1);
      rst = 1'b1;
      @(posedge clk); #1;

      // single points, one at a time
      for (int i = 0; i < 4; i++) begin
         r0 = m_rises;
         p0 = m_ldac_pulses;
         drive_point(tbl[i].x, tbl[i].y, tbl[i].ea, tbl[i].eb);
         wait_drain("table");
         chk("sclk_rises", m_rises - r0, 32);
         chk("ldac_pulses", m_ldac_pulses - p0, 1);
      end

      // back-to-back points
      @(posedge clk); #1;
      wr = 1'b1; x_in = 8'h00; y_in = 8'hFF;
      sb_q.push_back(16'h3000); sb_q.push_back(16'hBFF0);
      @(posedge clk); #1;
      x_in = 8'hFF; y_in = 8'h00;
      sb_q.push_back(16'h3FF0); sb_q.push_back(16'hB000);
      @(posedge clk); #1;
      wr = 1'b0;
      wait_drain("b2b");
      chk("b2b_spacing", m_since_ldac, 1);

      // overflow: engine busy, five writes into a four-deep FIFO
      do_reset();
      chk("ovf_clear_after_rst", overflow, 0);
      drive_point(8'h11, 8'h22, frame_x(8'h11), frame_y(8'h22));
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         wr = 1'b1; x_in = 8'h20 + 8'(i); y_in = 8'h40 + 8'(i);
         if (i < 4) begin
            sb_q.push_back(frame_x(x_in));
            sb_q.push_back(frame_y(y_in));
         end
         @(posedge clk); #1;
         chk("ready_fill", ready, (i < 3) ? 1 : 0);
         chk("overflow_fill", overflow, (i == 4) ? 1 : 0);
      end
      wr = 1'b0;
      wait_drain("overflow");
      chk("overflow_sticky", overflow, 1);
      chk("ready_after_drain", ready, 1);

      // full FIFO, write lands in the pop cycle
      do_reset();
      drive_point(8'h55, 8'hAA, frame_x(8'h55), frame_y(8'hAA));
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         wr = 1'b1; x_in = 8'h60 + 8'(i); y_in = 8'h90 + 8'(i);
         sb_q.push_back(frame_x(x_in));
         sb_q.push_back(frame_y(y_in));
         @(posedge clk); #1;
      end
      wr = 1'b0;
      chk("ready_full", ready, 0);
      prev  = ldac_n;
      found = 1'b0;
      for (int t = 0; t < 600; t++) begin
         @(posedge clk); #1;
         if (!prev && ldac_n) begin
            found = 1'b1;
            break;
         end
         prev = ldac_n;
      end
      chk("ldac_rise_seen", found, 1);
      wr = 1'b1; x_in = 8'h77; y_in = 8'h88;
      sb_q.push_back(frame_x(8'h77));
      sb_q.push_back(frame_y(8'h88));
      @(posedge clk); #1;
      wr = 1'b0;
      chk("pop_push_overflow", overflow, 0);
      chk("pop_push_ready", ready, 0);
      wait_drain("pop_push");
      chk("pop_push_overflow_end", overflow, 0);

      // reset during bit 7 of frame B
      drive_point(8'h5A, 8'hC3, 16'h35A0, 16'hBC30);
      found = 1'b0;
      for (int t = 0; t < 1000; t++) begin
         @(posedge clk); #1;
         if (m_inframe && m_fidx && m_nbits == 9) begin
            found = 1'b1;
            break;
         end
      end
      chk("rst_bit7_seen", found, 1);
      p0  = m_ldac_pulses;
      rst = 1'b0;
      #1;
      chk("abort_cs_n", cs_n, 1);
      chk("abort_sclk", sclk, 0);
      chk("abort_ldac_n", ldac_n, 1);
      chk("abort_ready", ready, 1);
      chk("abort_mosi", mosi, 0);
      sb_q.delete();
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_ldac", m_ldac_pulses - p0, 0);
      chk("abort_idle_cs_n", cs_n, 1);
      drive_point(8'h81, 8'h7F, 16'h3810, 16'hB7F0);
      wait_drain("after_abort");
      chk("after_abort_ldac", m_ldac_pulses - p0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
